// File: rtl/param_register_file.sv
// Parameterised 2-read/1-write register file with byte-lane writes and
// a self-clearing start-up sequence that zeroes every entry after reset.
module param_register_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [ADDR_W-1:0]     ReadRegister1,
  input  logic [ADDR_W-1:0]     ReadRegister2,
  input  logic [ADDR_W-1:0]     WriteRegister,
  input  logic [DATA_W-1:0]     WriteData,
  input  logic [DATA_W/8-1:0]   ByteEnable,
  input  logic                  RegWrite,
  output logic [DATA_W-1:0]     ReadData1,
  output logic [DATA_W-1:0]     ReadData2,
  output logic                  Ready,
  output logic                  WriteDropped
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BYTES = DATA_W / 8;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clear_idx;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wr_eff;
  logic [DATA_W-1:0]   wr_merged;
  logic [DATA_W-1:0]   rd1_next;
  logic [DATA_W-1:0]   rd2_next;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [BYTES-1:0]  be
  );
    logic [DATA_W-1:0] r;
    r = old_val;
    for (int i = 0; i < BYTES; i++)
      if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] read_sel(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              hit,
    input logic [DATA_W-1:0] fwd
  );
    logic [DATA_W-1:0] v;
    if (ZERO_REG != 0 && addr == '0) v = '0;
    else if (BYPASS != 0 && hit)     v = fwd;
    else                             v = stored;
    return v;
  endfunction

  // Writes to a hardwired-zero entry are not effective, so they never forward.
  always_comb begin
    wr_eff    = (state == RUN) && RegWrite && !(ZERO_REG != 0 && WriteRegister == '0);
    wr_merged = merge_bytes(mem[WriteRegister], WriteData, ByteEnable);
    rd1_next  = read_sel(ReadRegister1, mem[ReadRegister1],
                         wr_eff && (ReadRegister1 == WriteRegister), wr_merged);
    rd2_next  = read_sel(ReadRegister2, mem[ReadRegister2],
                         wr_eff && (ReadRegister2 == WriteRegister), wr_merged);
  end

  // Array has no reset of its own; the CLEAR walk is what initialises it.
  always_ff @(posedge Clk) begin
    if (state == CLEAR)
      mem[clear_idx] <= '0;
    else if (wr_eff)
      mem[WriteRegister] <= wr_merged;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= CLEAR;
      clear_idx    <= '0;
      Ready        <= 1'b0;
      WriteDropped <= 1'b0;
      ReadData1    <= '0;
      ReadData2    <= '0;
    end else if (state == CLEAR) begin
      clear_idx    <= clear_idx + ADDR_W'(1);
      WriteDropped <= RegWrite;
      ReadData1    <= '0;
      ReadData2    <= '0;
      if (clear_idx == '1) begin
        state <= RUN;
        Ready <= 1'b1;
      end
    end else begin
      WriteDropped <= 1'b0;
      ReadData1    <= rd1_next;
      ReadData2    <= rd2_next;
    end
  end

endmodule
